// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrt_en,
  input  logic [ADDR_WIDTH-1:0] reg1_addr,
  input  logic [ADDR_WIDTH-1:0] reg2_addr,
  input  logic [ADDR_WIDTH-1:0] reg_wrt_addr,
  input  logic [DATA_WIDTH-1:0] reg_wrt_data,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wrt_hit_s;

  // Next-state of the array: one register updated, writes to x0 dropped.
  always_comb begin
    regs_d    = regs_q;
    wrt_hit_s = wrt_en && (reg_wrt_addr != {ADDR_WIDTH{1'b0}});
    if (wrt_hit_s) begin
      regs_d[reg_wrt_addr] = reg_wrt_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Array state; reset takes priority over any write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; address 0 is forced to zero so x0 is never X, even pre-reset.
  always_comb begin
    if (reg1_addr == {ADDR_WIDTH{1'b0}}) begin
      reg1_data = {DATA_WIDTH{1'b0}};
    end else begin
      reg1_data = regs_q[reg1_addr];
    end
    if (reg2_addr == {ADDR_WIDTH{1'b0}}) begin
      reg2_data = {DATA_WIDTH{1'b0}};
    end else begin
      reg2_data = regs_q[reg2_addr];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wrt_en;
  logic [4:0]  reg1_addr;
  logic [4:0]  reg2_addr;
  logic [4:0]  reg_wrt_addr;
  logic [31:0] reg_wrt_data;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl   [32];
  bit          known [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrt_en       (wrt_en),
    .reg1_addr    (reg1_addr),
    .reg2_addr    (reg2_addr),
    .reg_wrt_addr (reg_wrt_addr),
    .reg_wrt_data (reg_wrt_data),
    .reg1_data    (reg1_data),
    .reg2_data    (reg2_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      known[i] = 1'b0;
      mdl[i]   = 32'h0;
    end
  end

  // Reference model: reset clears everything, a write lands on the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mdl[i]   = 32'h0;
        known[i] = 1'b1;
      end
    end else if (wrt_en && reg_wrt_addr != 5'd0) begin
      mdl[reg_wrt_addr]   = reg_wrt_data;
      known[reg_wrt_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  function automatic bit model_known(input logic [4:0] a);
    return (a == 5'd0) ? 1'b1 : known[a];
  endfunction

  // Per-cycle comparison of both read ports against the model.
  always @(negedge clk) begin
    if (model_known(reg1_addr)) begin
      n_cmp++;
      if (reg1_data !== model_read(reg1_addr)) begin
        n_bad++;
        $display("FAIL model_port1 t=%0t addr=%0d got=%h want=%h",
                 $time, reg1_addr, reg1_data, model_read(reg1_addr));
      end
    end
    if (model_known(reg2_addr)) begin
      n_cmp++;
      if (reg2_data !== model_read(reg2_addr)) begin
        n_bad++;
        $display("FAIL model_port2 t=%0t addr=%0d got=%h want=%h",
                 $time, reg2_addr, reg2_data, model_read(reg2_addr));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Present a write, take one edge, settle 2 time units after it.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wrt_en       = 1'b1;
    reg_wrt_addr = a;
    reg_wrt_data = d;
    @(posedge clk);
    #2;
    wrt_en = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    wrt_en       = 1'b0;
    reg1_addr    = 5'd0;
    reg2_addr    = 5'd0;
    reg_wrt_addr = 5'd0;
    reg_wrt_data = 32'h0;

    #5;
    chk("x0_prereset_p1", reg1_data, 32'h0);
    chk("x0_prereset_p2", reg2_data, 32'h0);

    // Basic write/read on the 20 ns grid.
    #10;
    rst          = 1'b0;
    wrt_en       = 1'b1;
    reg_wrt_addr = 5'd5;
    reg_wrt_data = 32'h1;
    reg1_addr    = 5'd3;
    reg2_addr    = 5'd4;
    @(posedge clk);
    #5;
    wrt_en = 1'b0;
    chk("basic_rs1_x3", reg1_data, 32'h0);
    chk("basic_rs2_x4", reg2_data, 32'h0);
    reg1_addr = 5'd5;
    #1;
    chk("basic_x5", reg1_data, 32'h1);
    #4;
    wrt_en       = 1'b1;
    reg_wrt_addr = 5'd10;
    reg_wrt_data = 32'd10;
    @(posedge clk);
    #2;
    wrt_en    = 1'b0;
    reg2_addr = 5'd10;
    #1;
    chk("basic_x10", reg2_data, 32'h0000000A);
    chk("basic_x5_kept", reg1_data, 32'h1);

    // Write-enable gating.
    wrt_en       = 1'b0;
    reg_wrt_addr = 5'd12;
    reg_wrt_data = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #2;
    reg1_addr = 5'd12;
    #1;
    chk("gated_x12", reg1_data, 32'h0);

    // x0 hardwiring.
    wr(5'd0, 32'h12345678);
    reg1_addr = 5'd0;
    reg2_addr = 5'd0;
    #1;
    chk("x0_write_p1", reg1_data, 32'h0);
    chk("x0_write_p2", reg2_data, 32'h0);

    // Read-during-write: old value before the edge, new value after.
    wr(5'd9, 32'hAA);
    reg1_addr    = 5'd9;
    wrt_en       = 1'b1;
    reg_wrt_addr = 5'd9;
    reg_wrt_data = 32'hBB;
    #1;
    chk("rdw_before", reg1_data, 32'hAA);
    @(posedge clk);
    #2;
    wrt_en = 1'b0;
    chk("rdw_after", reg1_data, 32'hBB);
    reg2_addr = 5'd9;
    #1;
    chk("dual_p1", reg1_data, 32'hBB);
    chk("dual_p2", reg2_data, 32'hBB);

    // Reset priority over a same-edge write.
    wr(5'd3, 32'h11);
    rst          = 1'b1;
    wrt_en       = 1'b1;
    reg_wrt_addr = 5'd3;
    reg_wrt_data = 32'h55;
    @(posedge clk);
    #2;
    rst       = 1'b0;
    wrt_en    = 1'b0;
    reg1_addr = 5'd3;
    #1;
    chk("rst_priority_x3", reg1_data, 32'h0);

    // Reset clear and full scan.
    wr(5'd7, 32'hDEADBEEF);
    reg1_addr = 5'd7;
    #1;
    chk("pre_clear_x7", reg1_data, 32'hDEADBEEF);
    pulse_rst();
    #1;
    chk("clear_x7", reg1_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      reg1_addr = a[4:0];
      reg2_addr = 5'(31 - a);
      #1;
      chk("clear_scan_p1", reg1_data, 32'h0);
      chk("clear_scan_p2", reg2_data, 32'h0);
    end

    // First edge after reset deasserts performs its write.
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wr(5'd31, 32'hCAFEF00D);
    reg2_addr = 5'd31;
    #1;
    chk("post_rst_write_x31", reg2_data, 32'hCAFEF00D);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      rst          = ($urandom_range(0, 63) == 0);
      wrt_en       = $urandom_range(0, 3) != 0;
      reg_wrt_addr = 5'($urandom);
      reg_wrt_data = $urandom;
      reg1_addr    = ($urandom_range(0, 3) == 0) ? reg_wrt_addr : 5'($urandom);
      reg2_addr    = ($urandom_range(0, 3) == 0) ? reg1_addr : 5'($urandom);
    end
    @(posedge clk);
    #2;
    rst    = 1'b0;
    wrt_en = 1'b0;
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
